// File: rtl/text_line_renderer.sv
// Single-line text overlay: character buffer with clear sweep, a pixel-to-glyph
// stage that drives the font ROM, and a bitmap sampling stage producing text_on.
`timescale 1ns/1ps
module text_line_renderer #(
   parameter int unsigned NUM_CHARS  = 16,
   parameter int          X0         = 0,
   parameter int          Y0         = 0,
   parameter int unsigned SCALE_LOG2 = 1
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         wr_en,
   input  logic [$clog2(NUM_CHARS)-1:0] wr_idx,
   input  logic [7:0]                   wr_char,
   input  logic                         clear,
   output logic                         busy,
   input  logic                         pix_en,
   input  logic [9:0]                   pix_x,
   input  logic [9:0]                   pix_y,
   output logic [7:0]                   font_char,
   output logic [2:0]                   font_row,
   input  logic [7:0]                   font_bitmap,
   output logic                         text_on,
   output logic                         text_valid
);

   localparam int unsigned AW     = $clog2(NUM_CHARS);
   localparam int unsigned SH     = 3 + SCALE_LOG2;
   localparam logic [11:0] LINE_W = 12'(NUM_CHARS << SH);
   localparam logic [9:0]  LINE_H = 10'(8 << SCALE_LOG2);

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   state_t          r_state;
   state_t          w_next;
   logic [AW-1:0]   r_clr_idx;
   logic [7:0]      r_buf [NUM_CHARS];
   logic            w_busy;
   logic            w_buf_wr;
   logic            w_clr_wr;

   logic signed [10:0] w_rel_x;
   logic signed [10:0] w_rel_y;
   logic               w_inside;
   logic [9:0]         w_col;
   logic [2:0]         w_bit;
   logic [2:0]         w_row;
   logic [7:0]         w_char;
   logic [7:0]         w_glyph;

   logic               r_s1_valid;
   logic               r_s1_inside;
   logic [7:0]         r_s1_char;
   logic [2:0]         r_s1_row;
   logic [2:0]         r_s1_bit;
   logic               r_text_on;
   logic               r_text_valid;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (clear) w_next = S_CLEAR;
         S_CLEAR: if (r_clr_idx == AW'(NUM_CHARS - 1)) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // A clear request in IDLE takes priority over a same-cycle write.
   always_comb begin
      w_busy   = (r_state == S_CLEAR);
      w_clr_wr = w_busy;
      w_buf_wr = (r_state == S_IDLE) && wr_en && !clear;
   end

   assign busy = w_busy;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_clr_idx <= '0;
         for (int unsigned i = 0; i < NUM_CHARS; i++) r_buf[i] <= 8'h20;
      end else if (w_clr_wr) begin
         r_buf[r_clr_idx] <= 8'h20;
         r_clr_idx        <= r_clr_idx + AW'(1);
      end else if (w_buf_wr) begin
         r_buf[wr_idx] <= wr_char;
      end
   end

   assign w_rel_x  = $signed({1'b0, pix_x}) - $signed(11'(X0));
   assign w_rel_y  = $signed({1'b0, pix_y}) - $signed(11'(Y0));
   assign w_inside = !w_rel_x[10] && ({2'b00, w_rel_x[9:0]} < LINE_W) &&
                     !w_rel_y[10] && (w_rel_y[9:0] < LINE_H);
   assign w_col    = w_rel_x[9:0] >> SH;
   assign w_bit    = w_rel_x[SCALE_LOG2 +: 3];
   assign w_row    = w_rel_y[SCALE_LOG2 +: 3];

   // Full-width column compare so no slot is aliased by truncated index bits.
   always_comb begin
      w_char = 8'h20;
      if (w_inside) begin
         for (int unsigned i = 0; i < NUM_CHARS; i++) begin
            if (w_col == 10'(i)) w_char = r_buf[i];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1_valid  <= 1'b0;
         r_s1_inside <= 1'b0;
         r_s1_char   <= '0;
         r_s1_row    <= '0;
         r_s1_bit    <= '0;
      end else begin
         r_s1_valid  <= pix_en;
         r_s1_inside <= w_inside;
         r_s1_char   <= w_char;
         r_s1_row    <= w_row;
         r_s1_bit    <= w_bit;
      end
   end

   assign w_glyph   = ((r_s1_char >= 8'h20) && (r_s1_char <= 8'h7E)) ? r_s1_char : 8'h20;
   assign font_char = w_glyph - 8'h20;
   assign font_row  = r_s1_row;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_text_on    <= 1'b0;
         r_text_valid <= 1'b0;
      end else begin
         r_text_on    <= r_s1_valid & r_s1_inside & font_bitmap[~r_s1_bit];
         r_text_valid <= r_s1_valid;
      end
   end

   assign text_on    = r_text_on;
   assign text_valid = r_text_valid;

endmodule

// File: tb/tb_text_line_renderer.sv
// Scoreboard bench for text_line_renderer: a default instance and an offset-origin
// instance, each with a small font ROM model and a queue-driven output monitor.
`timescale 1ns/1ps
module tb_text_line_renderer;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic       wr_en0, clear0, busy0, pix_en0, text_on0, text_valid0;
   logic [3:0] wr_idx0;
   logic [7:0] wr_char0, font_char0, font_bitmap0;
   logic [9:0] pix_x0, pix_y0;
   logic [2:0] font_row0;

   logic       wr_en1, clear1, busy1, pix_en1, text_on1, text_valid1;
   logic [3:0] wr_idx1;
   logic [7:0] wr_char1, font_char1, font_bitmap1;
   logic [9:0] pix_x1, pix_y1;
   logic [2:0] font_row1;

   text_line_renderer u_dut (
      .clk(clk), .reset(reset), .wr_en(wr_en0), .wr_idx(wr_idx0), .wr_char(wr_char0),
      .clear(clear0), .busy(busy0), .pix_en(pix_en0), .pix_x(pix_x0), .pix_y(pix_y0),
      .font_char(font_char0), .font_row(font_row0), .font_bitmap(font_bitmap0),
      .text_on(text_on0), .text_valid(text_valid0)
   );

   text_line_renderer #(.X0(100), .Y0(50)) u_off (
      .clk(clk), .reset(reset), .wr_en(wr_en1), .wr_idx(wr_idx1), .wr_char(wr_char1),
      .clear(clear1), .busy(busy1), .pix_en(pix_en1), .pix_x(pix_x1), .pix_y(pix_y1),
      .font_char(font_char1), .font_row(font_row1), .font_bitmap(font_bitmap1),
      .text_on(text_on1), .text_valid(text_valid1)
   );

   // Glyph codes not modelled return all-ones so a wrong code lights pixels.
   function automatic logic [7:0] font_rom(input logic [7:0] code, input logic [2:0] row);
      logic [63:0] g;
      int r;
      r = int'(row);
      case (code)
         8'h00:   g = 64'h0;
         8'h21:   g = 64'h3078CCCCFCCCCC00;
         8'h28:   g = 64'hCCCCCCFCCCCCCC00;
         8'h2F:   g = 64'h78CCCCCCCCCC7800;
         default: g = '1;
      endcase
      return g[63 - 8*r -: 8];
   endfunction

   assign font_bitmap0 = font_rom(font_char0, font_row0);
   assign font_bitmap1 = font_rom(font_char1, font_row1);

   typedef struct {
      bit         chk;
      logic [7:0] fc;
      logic [2:0] fr;
      logic       on;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   exp_t e0, e1;
   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] pfc0, pfc1;
   logic [2:0] pfr0, pfr1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (text_valid0) begin
         if (q0.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL u_dut text_valid without sample: got 1 expected 0");
         end else begin
            e0 = q0.pop_front();
            check("u_dut text_on", {31'b0, text_on0}, {31'b0, e0.on});
            if (e0.chk) begin
               check("u_dut font_char", {24'b0, pfc0}, {24'b0, e0.fc});
               check("u_dut font_row", {29'b0, pfr0}, {29'b0, e0.fr});
            end
         end
      end else begin
         check("u_dut bubble text_on", {31'b0, text_on0}, 32'd0);
      end
      pfc0 = font_char0;
      pfr0 = font_row0;
   end

   always @(negedge clk) begin
      if (text_valid1) begin
         if (q1.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL u_off text_valid without sample: got 1 expected 0");
         end else begin
            e1 = q1.pop_front();
            check("u_off text_on", {31'b0, text_on1}, {31'b0, e1.on});
            if (e1.chk) begin
               check("u_off font_char", {24'b0, pfc1}, {24'b0, e1.fc});
               check("u_off font_row", {29'b0, pfr1}, {29'b0, e1.fr});
            end
         end
      end else begin
         check("u_off bubble text_on", {31'b0, text_on1}, 32'd0);
      end
      pfc1 = font_char1;
      pfr1 = font_row1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample(input int inst, input int x, input int y, input logic on,
                         input bit chk, input logic [7:0] fc, input logic [2:0] fr);
      exp_t e;
      e.chk = chk; e.fc = fc; e.fr = fr; e.on = on;
      if (inst == 0) begin
         pix_en0 = 1'b1; pix_x0 = 10'(x); pix_y0 = 10'(y);
         q0.push_back(e);
      end else begin
         pix_en1 = 1'b1; pix_x1 = 10'(x); pix_y1 = 10'(y);
         q1.push_back(e);
      end
      tick();
   endtask

   task automatic idle(input int n);
      pix_en0 = 1'b0;
      pix_en1 = 1'b0;
      repeat (n) tick();
   endtask

   task automatic write(input int inst, input int idx, input logic [7:0] ch);
      if (inst == 0) begin
         wr_en0 = 1'b1; wr_idx0 = 4'(idx); wr_char0 = ch;
      end else begin
         wr_en1 = 1'b1; wr_idx1 = 4'(idx); wr_char1 = ch;
      end
      tick();
      wr_en0 = 1'b0;
      wr_en1 = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      wr_en0 = 0; wr_idx0 = 0; wr_char0 = 0; clear0 = 0; pix_en0 = 0; pix_x0 = 0; pix_y0 = 0;
      wr_en1 = 0; wr_idx1 = 0; wr_char1 = 0; clear1 = 0; pix_en1 = 0; pix_x1 = 0; pix_y1 = 0;
      #1 reset = 1'b1;

      // Reset held with live pixels: nothing may become valid.
      pix_en0 = 1'b1; pix_x0 = 10'd5; pix_y0 = 10'd6;
      repeat (3) tick();
      check("reset busy", {31'b0, busy0}, 32'd0);
      check("reset busy u_off", {31'b0, busy1}, 32'd0);
      check("reset text_on", {31'b0, text_on0}, 32'd0);
      check("reset text_valid", {31'b0, text_valid0}, 32'd0);
      check("reset font_char", {24'b0, font_char0}, 32'd0);
      check("reset font_row", {29'b0, font_row0}, 32'd0);
      reset = 1'b0;
      for (int y = 0; y <= 20; y += 3)
         for (int x = 0; x <= 300; x += 7)
            sample(0, x, y, 1'b0, 1'b0, 8'h00, 3'd0);
      idle(3);

      write(0, 0, 8'h48);
      sample(0, 0, 6, 1'b1, 1'b1, 8'h28, 3'd3);
      sample(0, 11, 6, 1'b1, 1'b1, 8'h28, 3'd3);
      sample(0, 12, 6, 1'b0, 1'b1, 8'h28, 3'd3);
      idle(1);

      write(0, 15, 8'h41);
      sample(0, 240, 8, 1'b1, 1'b1, 8'h21, 3'd4);
      sample(0, 256, 8, 1'b0, 1'b0, 8'h00, 3'd0);
      sample(0, 240, 16, 1'b0, 1'b0, 8'h00, 3'd0);
      idle(1);

      // Same-cycle write is not yet visible; the following cycle sees it.
      wr_en0 = 1'b1; wr_idx0 = 4'd1; wr_char0 = 8'h48;
      sample(0, 16, 6, 1'b0, 1'b1, 8'h00, 3'd3);
      wr_en0 = 1'b0;
      sample(0, 16, 6, 1'b1, 1'b1, 8'h28, 3'd3);
      idle(1);

      for (int i = 0; i < 16; i++) write(0, i, 8'h4F);
      sample(0, 0, 0, 1'b0, 1'b1, 8'h2F, 3'd0);
      sample(0, 2, 0, 1'b1, 1'b1, 8'h2F, 3'd0);
      idle(3);

      clear0 = 1'b1; wr_en0 = 1'b1; wr_idx0 = 4'd2; wr_char0 = 8'h48;
      tick();
      clear0 = 1'b0; wr_en0 = 1'b0;
      check("clear busy cycle 1", {31'b0, busy0}, 32'd1);
      for (int k = 2; k <= 16; k++) begin
         if (k == 5) clear0 = 1'b1;
         if (k == 11) begin
            wr_en0 = 1'b1; wr_idx0 = 4'd0; wr_char0 = 8'h48;
         end
         tick();
         clear0 = 1'b0; wr_en0 = 1'b0;
         check($sformatf("clear busy cycle %0d", k), {31'b0, busy0}, 32'd1);
      end
      tick();
      check("clear busy done", {31'b0, busy0}, 32'd0);
      for (int y = 0; y < 16; y++)
         for (int x = 0; x < 260; x++)
            sample(0, x, y, 1'b0, 1'b0, 8'h00, 3'd0);
      idle(3);

      write(0, 10, 8'h4F);
      clear0 = 1'b1;
      tick();
      clear0 = 1'b0;
      repeat (4) tick();
      check("mid-clear busy before reset", {31'b0, busy0}, 32'd1);
      reset = 1'b1;
      #1;
      check("mid-clear busy at reset", {31'b0, busy0}, 32'd0);
      tick();
      reset = 1'b0;
      sample(0, 162, 0, 1'b0, 1'b1, 8'h00, 3'd0);
      idle(3);
      clear0 = 1'b1;
      tick();
      clear0 = 1'b0;
      check("re-clear busy", {31'b0, busy0}, 32'd1);
      repeat (16) tick();
      check("re-clear busy done", {31'b0, busy0}, 32'd0);

      write(1, 0, 8'h48);
      sample(1, 99, 56, 1'b0, 1'b0, 8'h00, 3'd0);
      sample(1, 100, 56, 1'b1, 1'b1, 8'h28, 3'd3);
      sample(1, 100, 49, 1'b0, 1'b0, 8'h00, 3'd0);
      idle(3);
      write(1, 0, 8'h01);
      for (int y = 50; y < 66; y += 5)
         for (int x = 100; x < 116; x += 3)
            sample(1, x, y, 1'b0, 1'b1, 8'h00, 3'(((y - 50) >> 1) & 7));
      idle(4);

      check("u_dut queue drained", q0.size(), 32'd0);
      check("u_off queue drained", q1.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/text_line_renderer.md
# text_line_renderer

Renders a single line of ASCII text into the VGA pixel stream. The block holds a small character buffer that game logic writes, such as score or status text. It converts each scanned pixel coordinate into a glyph code and row for the font ROM, then samples the returned 8-bit bitmap row to produce a registered `text_on` pixel flag for the colour mapper. It drives the font ROM's request side and consumes its bitmap.

## Interface

- `NUM_CHARS`, default 16: buffer length in characters; power of two, 2..64.
- `X0`, default 0: left edge of the text line, in screen pixels.
- `Y0`, default 0: top edge of the text line, in screen pixels.
- `SCALE_LOG2`, default 1: each glyph pixel is drawn as a (1<<SCALE_LOG2)-square block; allowed values 0..2.

- `clk`  in  1  system/pixel clock.
- `reset`  in  1  asynchronous, active-high reset.
- `wr_en`  in  1  buffer write strobe.
- `wr_idx`  in  $clog2(NUM_CHARS)  character slot to write.
- `wr_char`  in  8  ASCII code to store.
- `clear`  in  1  single-cycle request to fill the buffer with spaces.
- `busy`  out  1  high while a clear sweep is running.
- `pix_en`  in  1  `pix_x`/`pix_y` are valid this cycle.
- `pix_x`  in  10  horizontal pixel coordinate.
- `pix_y`  in  10  vertical pixel coordinate.
- `font_char`  out  8  glyph code to the font ROM (ASCII − 0x20).
- `font_row`  out  3  glyph row to the font ROM.
- `font_bitmap`  in  8  font ROM row data, combinational from `font_char`/`font_row`; bit 7 is the leftmost pixel.
- `text_on`  out  1  pixel is a lit glyph pixel.
- `text_valid`  out  1  `text_on` corresponds to an accepted `pix_en` sample.

## Operation

**Buffer**
- `NUM_CHARS` × 8-bit registers; every entry resets to 0x20.
- A write takes effect when `wr_en=1` and the FSM is in IDLE: `buf[wr_idx] <= wr_char`.

**Clear FSM (states IDLE, CLEAR)**
- IDLE with `clear=1` → CLEAR. In this cycle the clear wins and any simultaneous `wr_en` is dropped.
- CLEAR writes 0x20 to one slot per cycle, at index 0, 1, … `NUM_CHARS`−1, then returns to IDLE.
- `busy=1` exactly while in CLEAR, for `NUM_CHARS` cycles.
- `wr_en` and `clear` are ignored while in CLEAR.

**Stage 1 (registered on every clk)**
- `rel_x = pix_x − X0` and `rel_y = pix_y − Y0`, computed 11-bit signed.
- `inside` = `rel_x ≥ 0`, `rel_x < NUM_CHARS<<(3+SCALE_LOG2)`, `rel_y ≥ 0`, and `rel_y < 8<<SCALE_LOG2`.
- `col = rel_x >> (3+SCALE_LOG2)`.
- `bitcol = (rel_x >> SCALE_LOG2) & 7`.
- `row = (rel_y >> SCALE_LOG2) & 7`.
- Registered outputs: `s1_valid <= pix_en`, `s1_inside`, `s1_char <= buf[col]` (0x20 when not inside), `s1_row`, `s1_bit`.

**Font request (combinational from stage 1)**
- `font_char = (s1_char in 0x20..0x7E ? s1_char : 0x20) − 0x20`.
- `font_row = s1_row`.

**Stage 2**
- `text_on <= s1_valid & s1_inside & font_bitmap[7 − s1_bit]`.
- `text_valid <= s1_valid`.

## Timing

- All state is updated on the `clk` rising edge, with asynchronous `reset`.
- Values after reset:
  - `busy=0`, `text_on=0`, `text_valid=0`, `font_char=0x00`, `font_row=0`.
  - All stage-1 registers cleared; FSM in IDLE.
- Latency: a sample presented with `pix_en` in cycle N produces `text_on`/`text_valid` in cycle N+2. There is no stall; `pix_en=0` produces bubbles with `text_valid=0` and `text_on=0`.
- A buffer write in cycle N is visible to pixels sampled in cycle N+1 or later. A pixel sampled in the same cycle N reads the old value.
- A clear started in cycle N completes by cycle N+`NUM_CHARS`. Pixels sampled during the sweep see a mix of old and cleared slots; this is acceptable.
- Reset asserted mid-clear forces IDLE immediately; `busy` drops with reset and all slots return to 0x20.
- Coordinates wrap nowhere. Any pixel left of or above the origin, or beyond the last column or row, gives `text_on=0`.

## Test plan

- **Reset state:** assert `reset` with `pix_en=1` and scan x=0..300, y=0..20 → `busy=0`; `text_on=0` on every cycle; `text_valid` follows `pix_en` delayed by 2 cycles.
- **Single glyph, defaults:** write 0x48 ('H') to slot 0, then sample (x=0, y=6), (x=11, y=6), (x=12, y=6). These map to row 3 (bitmap 11111100) → `text_on` = 1, 1, 0 respectively, each 2 cycles after its sample. `font_char=0x28` and `font_row=3` one cycle after each sample.
- **Last slot and right boundary:** write 'A' (0x41) to slot 15. Sample x=240, y=8 (row 4 = 11111100, bit 0) → `text_on=1`, `font_char=0x21`. Sample x=256 → `text_on=0`. Sample y=16 → `text_on=0`.
- **Clear sweep:** fill all slots with 'O', then pulse `clear` → `busy=1` for exactly 16 cycles. A `wr_en` issued during the sweep is dropped. Afterwards a full scan gives `text_on=0` everywhere. `clear` and `wr_en` in the same IDLE cycle → the write is lost.
- **Out-of-range code and offset origin:** in an instance with X0=100, Y0=50, store 0x01. Sample x=99 → `text_on=0`. Sample the slot's cells → `font_char=0x00` and `text_on=0`.
- **Reset mid-clear:** assert `reset` 5 cycles into a sweep → `busy=0` immediately. After release, all slots read as spaces and a new `clear` is accepted.
